iterative_alu: RTL and testbench

//   Parametrised, registered ALU for the MIPS datapath, extended with multi-cycle

---
 rtl/iterative_alu.sv | 184 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_alu.sv
// Registered ALU with multi-cycle unsigned multiply (shift-add) and divide (restoring),
// one bit per clock; single-cycle ops publish on the accepting edge.
module iterative_alu #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          MD_ENABLE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_carry_out,
  output logic             o_div_by_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OpAnd   = 3'b000;
  localparam logic [2:0] OpOr    = 3'b001;
  localparam logic [2:0] OpAdd   = 3'b010;
  localparam logic [2:0] OpXor   = 3'b011;
  localparam logic [2:0] OpMultu = 3'b100;
  localparam logic [2:0] OpDivu  = 3'b101;
  localparam logic [2:0] OpSub   = 3'b110;
  localparam logic [2:0] OpSlt   = 3'b111;

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_dv;
  logic             r_is_div;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic             r_zero, r_ovf, r_cy, r_dbz;

  logic             w_accept, w_go_iter, w_last;
  logic [WIDTH:0]   w_add, w_sub;
  logic [WIDTH-1:0] w_sc_lo, w_sc_hi;
  logic             w_sc_ovf, w_sc_cy, w_sc_dbz;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;
  logic [WIDTH-1:0] w_acc_nxt, w_q_nxt;

  assign w_accept  = i_start && (r_state != StIter);
  assign w_go_iter = w_accept && MD_ENABLE && ((i_op == OpMultu) ||
                     ((i_op == OpDivu) && (i_b != '0)));
  assign w_last    = (r_state == StIter) && (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StFin: begin
        if (w_accept) w_state_nxt = w_go_iter ? StIter : StFin;
        else          w_state_nxt = StIdle;
      end
      StIter:  if (w_last) w_state_nxt = StFin;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    o_busy = (r_state == StIter);
    o_done = (r_state == StFin);
  end

  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + (WIDTH+1)'(1);

  always_comb begin
    w_sc_lo  = '0;
    w_sc_hi  = '0;
    w_sc_ovf = 1'b0;
    w_sc_cy  = 1'b0;
    w_sc_dbz = 1'b0;
    case (i_op)
      OpAnd: w_sc_lo = i_a & i_b;
      OpOr:  w_sc_lo = i_a | i_b;
      OpXor: w_sc_lo = i_a ^ i_b;
      OpAdd: begin
        w_sc_lo  = w_add[WIDTH-1:0];
        w_sc_cy  = w_add[WIDTH];
        w_sc_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpSub: begin
        w_sc_lo  = w_sub[WIDTH-1:0];
        w_sc_cy  = w_sub[WIDTH];
        w_sc_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OpSlt: w_sc_lo = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OpDivu: begin
        if (MD_ENABLE && (i_b == '0)) begin
          w_sc_lo  = '1;
          w_sc_hi  = i_a;
          w_sc_dbz = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // One iteration step: r_acc is product-high / partial remainder, r_q is multiplier / quotient.
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_dv} : '0);
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dv};

  always_comb begin
    if (r_is_div) begin
      if (!w_div_diff[WIDTH]) begin
        w_acc_nxt = w_div_diff[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_div_shift[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_mul_sum[WIDTH:1];
      w_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_dv     <= '0;
      r_is_div <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cy     <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= i_a;
      r_dv     <= i_b;
      r_is_div <= (i_op == OpDivu);
      if (!w_go_iter) begin
        r_lo   <= w_sc_lo;
        r_hi   <= w_sc_hi;
        r_zero <= (w_sc_lo == '0);
        r_ovf  <= w_sc_ovf;
        r_cy   <= w_sc_cy;
        r_dbz  <= w_sc_dbz;
      end
    end else if (r_state == StIter) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
      if (w_last) begin
        r_lo   <= w_q_nxt;
        r_hi   <= w_acc_nxt;
        r_zero <= (w_q_nxt == '0);
        r_ovf  <= !r_is_div && (w_acc_nxt != '0);
        r_cy   <= 1'b0;
        r_dbz  <= 1'b0;
      end
    end
  end

  assign o_result_lo   = r_lo;
  assign o_result_hi   = r_hi;
  assign o_zero        = r_zero;
  assign o_overflow    = r_ovf;
  assign o_carry_out   = r_cy;
  assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: WIDTH=32 and WIDTH=8 instances checked against an arithmetic model.
module tb_iterative_alu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst32, start32, z32, ov32, cy32, dz32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, lo32, hi32;
  logic        rst8, start8, z8, ov8, cy8, dz8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, lo8, hi8;

  int total = 0;
  int bad   = 0;

  iterative_alu #(.WIDTH(32), .MD_ENABLE(1'b1)) u_dut32 (
    .i_clk(clk), .i_reset(rst32), .i_start(start32), .i_op(op32), .i_a(a32), .i_b(b32),
    .o_result_lo(lo32), .o_result_hi(hi32), .o_zero(z32), .o_overflow(ov32),
    .o_carry_out(cy32), .o_div_by_zero(dz32), .o_busy(busy32), .o_done(done32)
  );

  iterative_alu #(.WIDTH(8), .MD_ENABLE(1'b1)) u_dut8 (
    .i_clk(clk), .i_reset(rst8), .i_start(start8), .i_op(op8), .i_a(a8), .i_b(b8),
    .o_result_lo(lo8), .o_result_hi(hi8), .o_zero(z8), .o_overflow(ov8),
    .o_carry_out(cy8), .o_div_by_zero(dz8), .o_busy(busy8), .o_done(done8)
  );

  typedef struct {
    logic [63:0] lo, hi;
    logic        z, ov, cy, dz, busy, done;
    int          lat;
  } res_t;

  // Reference model: plain arithmetic on w-bit unsigned values held in 64 bits.
  function automatic res_t model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input int w);
    res_t        e;
    logic [63:0] mask, s, bb;
    longint      sa, sb;
    mask = (64'd1 << w) - 64'd1;
    e.lo = '0; e.hi = '0; e.ov = 1'b0; e.cy = 1'b0; e.dz = 1'b0;
    e.busy = 1'b0; e.done = 1'b1; e.lat = 1;
    case (op)
      3'd0: e.lo = a & b;
      3'd1: e.lo = a | b;
      3'd3: e.lo = a ^ b;
      3'd2, 3'd6: begin
        bb   = (op == 3'd6) ? ((~b) & mask) : b;
        s    = a + bb + ((op == 3'd6) ? 64'd1 : 64'd0);
        e.lo = s & mask;
        e.cy = s[w];
        e.ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
      end
      3'd7: begin
        sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        e.lo = (sa < sb) ? 64'd1 : 64'd0;
      end
      3'd4: begin
        s     = a * b;
        e.lo  = s & mask;
        e.hi  = s >> w;
        e.ov  = (e.hi != 0);
        e.lat = w + 1;
      end
      default: begin
        if (b == 0) begin
          e.lo = mask; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b; e.lat = w + 1;
        end
      end
    endcase
    e.z = (e.lo == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b);
    if (w == 32) begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end else begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic sample(input int w, output res_t o);
    o.lat = 0;
    if (w == 32) begin
      o.lo = {32'b0, lo32}; o.hi = {32'b0, hi32}; o.z = z32; o.ov = ov32; o.cy = cy32;
      o.dz = dz32; o.busy = busy32; o.done = done32;
    end else begin
      o.lo = {56'b0, lo8}; o.hi = {56'b0, hi8}; o.z = z8; o.ov = ov8; o.cy = cy8;
      o.dz = dz8; o.busy = busy8; o.done = done8;
    end
  endtask

  task automatic check_res(input string tag, input res_t o, input res_t e);
    check({tag, "_lo"}, o.lo, e.lo);
    check({tag, "_hi"}, o.hi, e.hi);
    check({tag, "_flags"}, {o.z, o.ov, o.cy, o.dz}, {e.z, e.ov, e.cy, e.dz});
  endtask

  // Issue one op, wait for done within a bound, check latency, busy length, results and hold.
  task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input string tag);
    res_t e, o;
    int   n, busy_n;
    bit   got;
    e = model(op, a, b, w);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 3'($urandom_range(0, 7)), {32'b0, $urandom}, {32'b0, $urandom});
    n = 1; busy_n = 0; got = 1'b0;
    while (!got && n <= w + 4) begin
      sample(w, o);
      if (o.done) got = 1'b1;
      else begin
        if (o.busy) busy_n++;
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, "_lat"}, got ? n : 0, e.lat);
    check({tag, "_busy"}, busy_n, e.lat - 1);
    check_res(tag, o, e);
    @(posedge clk); #1;
    sample(w, o);
    check({tag, "_pulse"}, o.done, 1'b0);
    check({tag, "_hold"}, o.lo, e.lo);
  endtask

  task automatic busy_ignore();
    res_t e, o;
    int   n;
    bit   got;
    e = model(3'd4, 64'h1234_5678, 64'h9ABC_DEF0, 32);
    @(negedge clk);
    drive(32, 1'b1, 3'd4, 64'h1234_5678, 64'h9ABC_DEF0);
    @(posedge clk); #1;
    n = 1; got = 1'b0;
    while (!got && n <= 40) begin
      sample(32, o);
      if (o.done) got = 1'b1;
      else begin
        if (n == 5) drive(32, 1'b1, 3'd2, 64'd3, 64'd4);
        else        drive(32, 1'b0, 3'd2, 64'd0, 64'd0);
        @(posedge clk); #1;
        n++;
      end
    end
    check("ign_lat", got ? n : 0, e.lat);
    check_res("ign", o, e);
  endtask

  task automatic fin_issue();
    res_t e1, e2, o;
    int   n;
    bit   got;
    e1 = model(3'd5, 64'd1000, 64'd7, 32);
    e2 = model(3'd2, 64'd100, 64'd23, 32);
    @(negedge clk);
    drive(32, 1'b1, 3'd5, 64'd1000, 64'd7);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
    n = 1; got = 1'b0;
    while (!got && n <= 40) begin
      sample(32, o);
      if (o.done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("fin_div_lat", got ? n : 0, e1.lat);
    check_res("fin_div", o, e1);
    drive(32, 1'b1, 3'd2, 64'd100, 64'd23);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
    sample(32, o);
    check("fin_add_done", o.done, 1'b1);
    check_res("fin_add", o, e2);
  endtask

  task automatic reset_abort();
    res_t o;
    int   dones;
    @(negedge clk);
    drive(32, 1'b1, 3'd5, 64'd15, 64'd3);
    @(posedge clk); #1;
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst32 = 1'b1;
    @(posedge clk); #1;
    rst32 = 1'b0;
    sample(32, o);
    check("abort_out", {o.lo, o.hi}, 128'd0);
    check("abort_ctl", {o.z, o.ov, o.cy, o.dz, o.busy, o.done}, 6'd0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) dones++;
    end
    check("abort_no_done", dones, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res_t o;
    logic [63:0] ra, rb;
    rst32 = 1'b1; rst8 = 1'b1;
    // Start held during reset must lose.
    drive(32, 1'b1, 3'd2, 64'd1, 64'd1);
    drive(8, 1'b1, 3'd2, 64'd1, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    sample(32, o);
    check("rst32_res", {o.lo, o.hi}, 128'd0);
    check("rst32_ctl", {o.z, o.ov, o.cy, o.dz, o.busy, o.done}, 6'd0);
    sample(8, o);
    check("rst8_res", {o.lo, o.hi}, 128'd0);
    check("rst8_ctl", {o.z, o.ov, o.cy, o.dz, o.busy, o.done}, 6'd0);
    drive(32, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(8, 1'b0, 3'd0, 64'd0, 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;

    run_op(32, 3'd2, 64'd15, 64'd5, "add32");
    run_op(32, 3'd6, 64'd1, 64'd5, "sub32");
    run_op(32, 3'd6, 64'h8000_0000, 64'd1, "subovf32");
    run_op(32, 3'd7, 64'hFFFF_FFFD, 64'd1, "slt32");
    run_op(32, 3'd4, 64'hFFFF_FFFF, 64'hFFFF_FFFF, "mulmax32");
    run_op(32, 3'd5, 64'd15, 64'd3, "div32");
    run_op(32, 3'd5, 64'd15, 64'd0, "div0_32");
    run_op(8, 3'd2, 64'd15, 64'd5, "add8");
    run_op(8, 3'd6, 64'd1, 64'd5, "sub8");
    run_op(8, 3'd6, 64'h80, 64'd1, "subovf8");
    run_op(8, 3'd7, 64'hFD, 64'd1, "slt8");
    run_op(8, 3'd4, 64'hFF, 64'hFF, "mulmax8");

    busy_ignore();
    fin_issue();
    reset_abort();

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 20)) : {32'b0, $urandom};
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 :
           ($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 20)) : {32'b0, $urandom};
      run_op(32, 3'($urandom_range(0, 7)), ra, rb, "rnd32");
    end
    for (int i = 0; i < 30; i++) begin
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      run_op(8, 3'($urandom_range(0, 7)), ra, rb, "rnd8");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
